flow_reinit_arbiter: RTL

- Shares the single per-flow context RAM write port between two sources: engine context writeback and runtime per-flow re-initialisation requests.
- A re-initialisation writes the default context for one flow, then pushes that flow ID back into the scheduling FIFO.
- Sits beside the power-on RAM/FIFO reset sequencer and becomes active only after that sequencer reports completion.
- Engine writeback has priority; a starvation guard bounds how long re-init requests can wait.

---
 rtl/flow_reinit_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/flow_reinit_arbiter.sv
// ---------------------------------------------------------------------------
// flow_reinit_arbiter
//
// Shares the single write port of the per-flow context RAM between engine
// context writeback and runtime per-flow re-initialisation requests. A
// re-init writes rst_cntxt into one flow's context, then pushes that flow ID
// back into the scheduling FIFO. Nothing is granted until the power-on
// RAM/FIFO reset sequencer raises init_done. Engine writeback normally wins;
// a starvation counter forces a re-init grant after STARVE_LIMIT blocked
// cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   init_done           power-on reset sequence complete (enables arbitration)
//   rst_cntxt           default context written on re-init
//   reinit_req_*        re-init request handshake (val/rdy, flow ID)
//   eng_wr_*            engine writeback (val, flow ID, data) and grant (rdy)
//   cntxt_wr_*          registered context RAM write port
//   fifo_push_*         scheduling FIFO push port (val/rdy, flow ID)
//   busy                any re-init queued, being written or awaiting push
// ---------------------------------------------------------------------------
module flow_reinit_arbiter #(
    parameter int FLOW_ID_W    = 10,
    parameter int CNTXT_W      = 64,
    parameter int REQ_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic [CNTXT_W-1:0]   rst_cntxt,
    input  logic                 reinit_req_val,
    input  logic [FLOW_ID_W-1:0] reinit_req_flowid,
    output logic                 reinit_req_rdy,
    input  logic                 eng_wr_val,
    input  logic [FLOW_ID_W-1:0] eng_wr_flowid,
    input  logic [CNTXT_W-1:0]   eng_wr_data,
    output logic                 eng_wr_rdy,
    output logic                 cntxt_wr_val,
    output logic [FLOW_ID_W-1:0] cntxt_wr_flowid,
    output logic [CNTXT_W-1:0]   cntxt_wr_data,
    output logic                 fifo_push_val,
    output logic [FLOW_ID_W-1:0] fifo_push_flowid,
    input  logic                 fifo_push_rdy,
    output logic                 busy
);

    localparam int AW = $clog2(REQ_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [FLOW_ID_W-1:0] req_mem [REQ_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [CW-1:0]        starve_cnt;
    logic                 ws_reinit;

    logic active;
    logic fifo_empty;
    logic fifo_full;
    logic enq;
    logic push_drain;
    logic reinit_elig;
    logic starve_hit;
    logic grant_reinit;
    logic grant_eng;

    // Arbitration and handshakes. Gating with rst_n keeps the combinational
    // ready outputs at 0 while reset is asserted, matching the registers.
    always_comb begin
        active       = init_done & rst_n;
        fifo_empty   = (wr_ptr == rd_ptr);
        fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        // Full is taken before any pop this cycle, so no enqueue on full.
        reinit_req_rdy = active & ~fifo_full;
        enq            = reinit_req_val & reinit_req_rdy;
        push_drain     = fifo_push_val & fifo_push_rdy;
        // Only one re-init may be in flight: none in the write stage and the
        // push register free (or freeing this cycle).
        reinit_elig  = active & ~fifo_empty & ~(cntxt_wr_val & ws_reinit) &
                       (~fifo_push_val | fifo_push_rdy);
        starve_hit   = (starve_cnt == CW'(STARVE_LIMIT));
        grant_reinit = reinit_elig & (starve_hit | ~eng_wr_val);
        grant_eng    = active & eng_wr_val & ~(starve_hit & reinit_elig);
        eng_wr_rdy   = grant_eng;
        busy         = ~fifo_empty | (cntxt_wr_val & ws_reinit) | fifo_push_val;
    end

    // Request FIFO storage; contents need no reset because the pointers
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            req_mem[wr_ptr[AW-1:0]] <= reinit_req_flowid;
        end
    end

    // Request FIFO pointers. While init_done is low nothing can enqueue or
    // pop, so holding the flush for the whole low period has the same effect
    // as flushing on the sampled falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!init_done) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (grant_reinit) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Starvation counter: counts consecutive cycles in which an eligible
    // re-init lost to the engine, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!init_done || grant_reinit || !reinit_elig) begin
            starve_cnt <= '0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Write stage: one-cycle registered copy of whichever source was granted.
    // ws_reinit remembers that the write came from a re-init so that the
    // flow ID moves on to the push register afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntxt_wr_val    <= 1'b0;
            cntxt_wr_flowid <= '0;
            cntxt_wr_data   <= '0;
            ws_reinit       <= 1'b0;
        end else begin
            cntxt_wr_val <= grant_eng | grant_reinit;
            ws_reinit    <= grant_reinit;
            if (grant_eng) begin
                cntxt_wr_flowid <= eng_wr_flowid;
                cntxt_wr_data   <= eng_wr_data;
            end else if (grant_reinit) begin
                cntxt_wr_flowid <= req_mem[rd_ptr[AW-1:0]];
                cntxt_wr_data   <= rst_cntxt;
            end
        end
    end

    // Push register: loaded after a re-init write and held until the
    // scheduling FIFO accepts it. Eligibility guarantees it is free (or
    // draining) whenever a reload arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_push_val    <= 1'b0;
            fifo_push_flowid <= '0;
        end else if (cntxt_wr_val && ws_reinit) begin
            fifo_push_val    <= 1'b1;
            fifo_push_flowid <= cntxt_wr_flowid;
        end else if (push_drain) begin
            fifo_push_val    <= 1'b0;
        end
    end

endmodule
